// File: rtl/point_stepper_if.sv
// Initiator/target bundle between point_stepper and update_point: one begin pulse
// with held operands out, one result strobe with the stepped point back.
interface point_stepper_if #(
    parameter int unsigned POSITION_SIZE     = 8,
    parameter int unsigned VELOCITY_SIZE     = 8,
    parameter int unsigned ACCELERATION_SIZE = 8
);
    logic                                begin_out;
    logic signed [POSITION_SIZE-1:0]     pos_x_out;
    logic signed [POSITION_SIZE-1:0]     pos_y_out;
    logic signed [VELOCITY_SIZE-1:0]     vel_x_out;
    logic signed [VELOCITY_SIZE-1:0]     vel_y_out;
    logic signed [ACCELERATION_SIZE-1:0] accel_x_out;
    logic signed [ACCELERATION_SIZE-1:0] accel_y_out;
    logic                                result_in;
    logic signed [POSITION_SIZE-1:0]     new_pos_x_in;
    logic signed [POSITION_SIZE-1:0]     new_pos_y_in;
    logic signed [VELOCITY_SIZE-1:0]     new_vel_x_in;
    logic signed [VELOCITY_SIZE-1:0]     new_vel_y_in;

    modport master (
        output begin_out, pos_x_out, pos_y_out, vel_x_out, vel_y_out, accel_x_out, accel_y_out,
        input  result_in, new_pos_x_in, new_pos_y_in, new_vel_x_in, new_vel_y_in
    );

    modport slave (
        input  begin_out, pos_x_out, pos_y_out, vel_x_out, vel_y_out, accel_x_out, accel_y_out,
        output result_in, new_pos_x_in, new_pos_y_in, new_vel_x_in, new_vel_y_in
    );
endinterface

// File: rtl/point_stepper.sv
// Frame sequencer: steps every mass point through update_point once per frame request.
// Optional watchdog on the result wait is enabled by defining POINT_STEPPER_TIMEOUT_EN.
module point_stepper #(
    parameter int unsigned NUM_POINTS        = 8,
    parameter int unsigned POSITION_SIZE     = 8,
    parameter int unsigned VELOCITY_SIZE     = 8,
    parameter int unsigned ACCELERATION_SIZE = 8,
    parameter int unsigned TIMEOUT_CYCLES    = 64,
    localparam int unsigned IDX_W            = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                frame_start_in,
    input  logic signed [ACCELERATION_SIZE-1:0] accel_x_in,
    input  logic signed [ACCELERATION_SIZE-1:0] accel_y_in,
    input  logic                                init_we_in,
    input  logic        [IDX_W-1:0]             init_idx_in,
    input  logic signed [POSITION_SIZE-1:0]     init_pos_x_in,
    input  logic signed [POSITION_SIZE-1:0]     init_pos_y_in,
    input  logic signed [VELOCITY_SIZE-1:0]     init_vel_x_in,
    input  logic signed [VELOCITY_SIZE-1:0]     init_vel_y_in,
    input  logic        [IDX_W-1:0]             rd_idx_in,
    output logic signed [POSITION_SIZE-1:0]     rd_pos_x_out,
    output logic signed [POSITION_SIZE-1:0]     rd_pos_y_out,
    output logic signed [VELOCITY_SIZE-1:0]     rd_vel_x_out,
    output logic signed [VELOCITY_SIZE-1:0]     rd_vel_y_out,
    point_stepper_if.master                     up,
    output logic                                busy_out,
    output logic                                done_out,
    output logic                                timeout_out
);
    // Storage spans the full index space so any IDX_W-bit index selects a real slot;
    // slots at or above NUM_POINTS are never written and stay zero.
    localparam int unsigned Slots = 2 ** IDX_W;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic signed [ACCELERATION_SIZE-1:0] accel_x_q, accel_x_d, accel_y_q, accel_y_d;
    logic result_prev_q;

    logic signed [POSITION_SIZE-1:0] pos_x_q [Slots];
    logic signed [POSITION_SIZE-1:0] pos_x_d [Slots];
    logic signed [POSITION_SIZE-1:0] pos_y_q [Slots];
    logic signed [POSITION_SIZE-1:0] pos_y_d [Slots];
    logic signed [VELOCITY_SIZE-1:0] vel_x_q [Slots];
    logic signed [VELOCITY_SIZE-1:0] vel_x_d [Slots];
    logic signed [VELOCITY_SIZE-1:0] vel_y_q [Slots];
    logic signed [VELOCITY_SIZE-1:0] vel_y_d [Slots];

    logic signed [POSITION_SIZE-1:0] rd_pos_x_q, rd_pos_x_d, rd_pos_y_q, rd_pos_y_d;
    logic signed [VELOCITY_SIZE-1:0] rd_vel_x_q, rd_vel_x_d, rd_vel_y_q, rd_vel_y_d;

    logic accept;
    logic expire;
    logic advance;
    logic last_point;
    logic init_in_range;
    logic rd_in_range;

    // Level-held and pulsed results both count once: only a 0->1 transition is taken.
    assign accept        = (state_q == StWait) && up.result_in && !result_prev_q;
    assign advance       = accept || expire;
    assign last_point    = (idx_q == IDX_W'(NUM_POINTS - 1));
    assign init_in_range = (32'(init_idx_in) < NUM_POINTS);
    assign rd_in_range   = (32'(rd_idx_in) < NUM_POINTS);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        accel_x_d = accel_x_q;
        accel_y_d = accel_y_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        vel_x_d   = vel_x_q;
        vel_y_d   = vel_y_q;

        unique case (state_q)
            StIdle: begin
                if (init_we_in && init_in_range) begin
                    pos_x_d[init_idx_in] = init_pos_x_in;
                    pos_y_d[init_idx_in] = init_pos_y_in;
                    vel_x_d[init_idx_in] = init_vel_x_in;
                    vel_y_d[init_idx_in] = init_vel_y_in;
                end
                if (frame_start_in) begin
                    accel_x_d = accel_x_in;
                    accel_y_d = accel_y_in;
                    idx_d     = '0;
                    state_d   = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                // A watchdog expiry advances without touching the point.
                if (accept) begin
                    pos_x_d[idx_q] = up.new_pos_x_in;
                    pos_y_d[idx_q] = up.new_pos_y_in;
                    vel_x_d[idx_q] = up.new_vel_x_in;
                    vel_y_d[idx_q] = up.new_vel_y_in;
                end
                if (advance) begin
                    if (last_point) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StIssue;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Reads see the array before this cycle's writeback or init write.
    always_comb begin
        rd_pos_x_d = '0;
        rd_pos_y_d = '0;
        rd_vel_x_d = '0;
        rd_vel_y_d = '0;
        if (rd_in_range) begin
            rd_pos_x_d = pos_x_q[rd_idx_in];
            rd_pos_y_d = pos_y_q[rd_idx_in];
            rd_vel_x_d = vel_x_q[rd_idx_in];
            rd_vel_y_d = vel_y_q[rd_idx_in];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            accel_x_q     <= '0;
            accel_y_q     <= '0;
            result_prev_q <= 1'b0;
            pos_x_q       <= '{default: '0};
            pos_y_q       <= '{default: '0};
            vel_x_q       <= '{default: '0};
            vel_y_q       <= '{default: '0};
            rd_pos_x_q    <= '0;
            rd_pos_y_q    <= '0;
            rd_vel_x_q    <= '0;
            rd_vel_y_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            accel_x_q     <= accel_x_d;
            accel_y_q     <= accel_y_d;
            result_prev_q <= up.result_in;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            vel_x_q       <= vel_x_d;
            vel_y_q       <= vel_y_d;
            rd_pos_x_q    <= rd_pos_x_d;
            rd_pos_y_q    <= rd_pos_y_d;
            rd_vel_x_q    <= rd_vel_x_d;
            rd_vel_y_q    <= rd_vel_y_d;
        end
    end

`ifdef POINT_STEPPER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic timeout_q, timeout_d;

    // Counter holds the number of completed WAIT cycles for the current point.
    always_comb begin
        expire    = 1'b0;
        cnt_d     = '0;
        timeout_d = timeout_q;
        if ((state_q == StWait) && !accept) begin
            if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                expire    = 1'b1;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_out = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign expire             = 1'b0;
    assign timeout_out        = 1'b0;
`endif

    assign up.begin_out   = (state_q == StIssue);
    assign up.pos_x_out   = pos_x_q[idx_q];
    assign up.pos_y_out   = pos_y_q[idx_q];
    assign up.vel_x_out   = vel_x_q[idx_q];
    assign up.vel_y_out   = vel_y_q[idx_q];
    assign up.accel_x_out = accel_x_q;
    assign up.accel_y_out = accel_y_q;

    assign busy_out     = (state_q != StIdle);
    assign done_out     = (state_q == StDone);
    assign rd_pos_x_out = rd_pos_x_q;
    assign rd_pos_y_out = rd_pos_y_q;
    assign rd_vel_x_out = rd_vel_x_q;
    assign rd_vel_y_out = rd_vel_y_q;
endmodule

// File: tb/tb_point_stepper.sv
// Bench for point_stepper: a four-point instance driven by an update_point model with a
// begin/done scoreboard, plus a single-point instance exercised by hand.
module tb_point_stepper;
    localparam int N  = 4;
    localparam int TO = 8;

    typedef logic signed [7:0] s8_t;
    typedef struct {
        int  cyc;
        s8_t px, py, vx, vy, ax, ay;
    } beg_t;
    typedef struct {
        logic [1:0]  widx;
        s8_t         px, py, vx, vy;
        logic [1:0]  ridx;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Four-point instance
    logic       fs_a = 0, we_a = 0;
    s8_t        ax_a = 0, ay_a = 0, wpx_a = 0, wpy_a = 0, wvx_a = 0, wvy_a = 0;
    logic [1:0] widx_a = 0, ridx_a = 0;
    s8_t        rpx_a, rpy_a, rvx_a, rvy_a;
    logic       busy_a, done_a, to_a;

    point_stepper_if #(.POSITION_SIZE(8), .VELOCITY_SIZE(8), .ACCELERATION_SIZE(8)) bus_a ();

    point_stepper #(.NUM_POINTS(N), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk_in(clk), .rst_in(rst), .frame_start_in(fs_a),
        .accel_x_in(ax_a), .accel_y_in(ay_a),
        .init_we_in(we_a), .init_idx_in(widx_a),
        .init_pos_x_in(wpx_a), .init_pos_y_in(wpy_a),
        .init_vel_x_in(wvx_a), .init_vel_y_in(wvy_a),
        .rd_idx_in(ridx_a), .rd_pos_x_out(rpx_a), .rd_pos_y_out(rpy_a),
        .rd_vel_x_out(rvx_a), .rd_vel_y_out(rvy_a),
        .up(bus_a), .busy_out(busy_a), .done_out(done_a), .timeout_out(to_a)
    );

    // Single-point instance
    logic       fs_b = 0, we_b = 0;
    s8_t        ax_b = 0, ay_b = 0, wpx_b = 0, wpy_b = 0, wvx_b = 0, wvy_b = 0;
    logic [0:0] widx_b = 0, ridx_b = 0;
    s8_t        rpx_b, rpy_b, rvx_b, rvy_b;
    logic       busy_b, done_b, to_b;

    point_stepper_if #(.POSITION_SIZE(8), .VELOCITY_SIZE(8), .ACCELERATION_SIZE(8)) bus_b ();

    point_stepper #(.NUM_POINTS(1), .TIMEOUT_CYCLES(TO)) u_one (
        .clk_in(clk), .rst_in(rst), .frame_start_in(fs_b),
        .accel_x_in(ax_b), .accel_y_in(ay_b),
        .init_we_in(we_b), .init_idx_in(widx_b),
        .init_pos_x_in(wpx_b), .init_pos_y_in(wpy_b),
        .init_vel_x_in(wvx_b), .init_vel_y_in(wvy_b),
        .rd_idx_in(ridx_b), .rd_pos_x_out(rpx_b), .rd_pos_y_out(rpy_b),
        .rd_vel_x_out(rvx_b), .rd_vel_y_out(rvy_b),
        .up(bus_b), .busy_out(busy_b), .done_out(done_b), .timeout_out(to_b)
    );

    s8_t  sh_px[N], sh_py[N], sh_vx[N], sh_vy[N];
    beg_t exp_beg_q[$];
    int   exp_done_q[$];
    beg_t mon_e;
    int   mon_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // update_point model: answers L cycles after begin, holds result for H cycles,
    // returns pos+1 / vel-1; begin number m_skip gets no answer.
    int  m_lat = 5, m_hold = 1, m_skip = -1, m_n = 0, m_cd = 0, m_hl = 0;
    s8_t m_px, m_py, m_vx, m_vy;

    always @(negedge clk) begin
        if (rst) begin
            m_cd = 0;
            m_hl = 0;
            bus_a.result_in    = 1'b0;
            bus_a.new_pos_x_in = '0;
            bus_a.new_pos_y_in = '0;
            bus_a.new_vel_x_in = '0;
            bus_a.new_vel_y_in = '0;
        end else begin
            if (m_hl > 0) begin
                m_hl--;
                if (m_hl == 0) bus_a.result_in = 1'b0;
            end
            if (bus_a.begin_out) begin
                if (m_n != m_skip) begin
                    m_cd = m_lat;
                    m_px = bus_a.pos_x_out + 8'sd1;
                    m_py = bus_a.pos_y_out + 8'sd1;
                    m_vx = bus_a.vel_x_out - 8'sd1;
                    m_vy = bus_a.vel_y_out - 8'sd1;
                end
                m_n++;
            end else if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    bus_a.result_in    = 1'b1;
                    bus_a.new_pos_x_in = m_px;
                    bus_a.new_pos_y_in = m_py;
                    bus_a.new_vel_x_in = m_vx;
                    bus_a.new_vel_y_in = m_vy;
                    m_hl = m_hold;
                end
            end
        end
    end

    // Scoreboard: every begin and done must match the next expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.begin_out) begin
                chk("begin_expected", 64'(exp_beg_q.size() != 0), 64'd1);
                if (exp_beg_q.size() != 0) begin
                    mon_e = exp_beg_q.pop_front();
                    chk("begin_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("begin_operands",
                        {bus_a.pos_x_out, bus_a.pos_y_out, bus_a.vel_x_out, bus_a.vel_y_out,
                         bus_a.accel_x_out, bus_a.accel_y_out},
                        {mon_e.px, mon_e.py, mon_e.vx, mon_e.vy, mon_e.ax, mon_e.ay});
                end
            end
            if (done_a) begin
                chk("done_expected", 64'(exp_done_q.size() != 0), 64'd1);
                if (exp_done_q.size() != 0) begin
                    mon_d = exp_done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mon_d));
                end
            end
        end
    end

    task automatic rd_all(input string name);
        for (int i = 0; i < N; i++) begin
            ridx_a = 2'(i);
            tick();
            chk($sformatf("%s_rd%0d", name, i), {rpx_a, rpy_a, rvx_a, rvy_a},
                {sh_px[i], sh_py[i], sh_vx[i], sh_vy[i]});
        end
    endtask

    task automatic run_frame(input int lat, input int hold, input s8_t ax, input s8_t ay,
                             input int skip, input bit poke, input string name);
        int   t;
        beg_t e;
        m_lat  = lat;
        m_hold = hold;
        m_skip = skip;
        m_n    = 0;
        t      = cyc + 1;
        for (int i = 0; i < N; i++) begin
            e = '{t, sh_px[i], sh_py[i], sh_vx[i], sh_vy[i], ax, ay};
            exp_beg_q.push_back(e);
            if (i == skip) begin
                t += TO + 1;
            end else begin
                t += lat + 1;
                sh_px[i] = sh_px[i] + 8'sd1;
                sh_py[i] = sh_py[i] + 8'sd1;
                sh_vx[i] = sh_vx[i] - 8'sd1;
                sh_vy[i] = sh_vy[i] - 8'sd1;
            end
        end
        exp_done_q.push_back(t);
        fs_a = 1; ax_a = ax; ay_a = ay;
        tick();
        fs_a = 0; ax_a = ~ax; ay_a = ~ay;
        if (poke) begin
            tick();
            tick();
            fs_a = 1; we_a = 1; widx_a = 2'd2;
            wpx_a = 99; wpy_a = 99; wvx_a = 99; wvy_a = 99;
            tick();
            fs_a = 0; we_a = 0;
        end
        for (int b = 0; b < 400 && exp_done_q.size() != 0; b++) tick();
        chk({name, "_done_seen"}, 64'(exp_done_q.size()), 64'd0);
        for (int b = 0; b < 4; b++) tick();
        chk({name, "_begins_left"}, 64'(exp_beg_q.size()), 64'd0);
        chk({name, "_idle"}, {63'd0, busy_a}, 64'd0);
        exp_done_q.delete();
        exp_beg_q.delete();
        rd_all(name);
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{2'd0, 8'sd10, -8'sd20, 8'sd3, -8'sd4, 2'd0, {8'sd10, -8'sd20, 8'sd3, -8'sd4}};
        vt[1] = '{2'd1, -8'sd128, 8'sd127, -8'sd1, 8'sd1, 2'd1,
                  {-8'sd128, 8'sd127, -8'sd1, 8'sd1}};
        vt[2] = '{2'd2, 8'sd5, 8'sd6, 8'sd7, 8'sd8, 2'd0, {8'sd10, -8'sd20, 8'sd3, -8'sd4}};
        vt[3] = '{2'd3, -8'sd3, -8'sd2, -8'sd1, 8'sd0, 2'd3, {-8'sd3, -8'sd2, -8'sd1, 8'sd0}};
        vt[4] = '{2'd2, 8'sd50, 8'sd60, 8'sd70, -8'sd80, 2'd2,
                  {8'sd50, 8'sd60, 8'sd70, -8'sd80}};
        vt[5] = '{2'd0, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 2'd1, {-8'sd128, 8'sd127, -8'sd1, 8'sd1}};
        for (int i = 0; i < N; i++) begin
            sh_px[i] = 0; sh_py[i] = 0; sh_vx[i] = 0; sh_vy[i] = 0;
        end
        bus_b.result_in    = 1'b0;
        bus_b.new_pos_x_in = '0;
        bus_b.new_pos_y_in = '0;
        bus_b.new_vel_x_in = '0;
        bus_b.new_vel_y_in = '0;

        // Reset for one cycle
        rst = 1;
        tick();
        rst = 0;
        chk("rst_ctrl_a", {busy_a, done_a, to_a, bus_a.begin_out}, 4'd0);
        chk("rst_ops_a", {bus_a.pos_x_out, bus_a.pos_y_out, bus_a.vel_x_out, bus_a.vel_y_out,
                          bus_a.accel_x_out, bus_a.accel_y_out}, 48'd0);
        chk("rst_rd_a", {rpx_a, rpy_a, rvx_a, rvy_a}, 32'd0);
        chk("rst_ctrl_b", {busy_b, done_b, to_b, bus_b.begin_out}, 4'd0);
        rd_all("rst");

        // Init writes and readback from the table
        for (int i = 0; i < 6; i++) begin
            we_a = 1; widx_a = vt[i].widx;
            wpx_a = vt[i].px; wpy_a = vt[i].py; wvx_a = vt[i].vx; wvy_a = vt[i].vy;
            sh_px[vt[i].widx] = vt[i].px; sh_py[vt[i].widx] = vt[i].py;
            sh_vx[vt[i].widx] = vt[i].vx; sh_vy[vt[i].widx] = vt[i].vy;
            tick();
            we_a = 0; ridx_a = vt[i].ridx;
            tick();
            chk($sformatf("vec%0d_rd", i), {rpx_a, rpy_a, rvx_a, rvy_a}, vt[i].exp);
        end

        // Same-cycle write and read of one index returns the old value
        we_a = 1; widx_a = 2'd3; ridx_a = 2'd3;
        wpx_a = 9; wpy_a = 9; wvx_a = 9; wvy_a = 9;
        tick();
        we_a = 0;
        chk("rd_old_on_write", {rpx_a, rpy_a, rvx_a, rvy_a}, {-8'sd3, -8'sd2, -8'sd1, 8'sd0});
        tick();
        chk("rd_new_after_write", {rpx_a, rpy_a, rvx_a, rvy_a}, {8'sd9, 8'sd9, 8'sd9, 8'sd9});
        sh_px[3] = 9; sh_py[3] = 9; sh_vx[3] = 9; sh_vy[3] = 9;

        run_frame(5, 1, 8'sd3, -8'sd2, -1, 1'b0, "pulse");
        run_frame(5, 4, -8'sd1, 8'sd7, -1, 1'b0, "held");
        run_frame(2, 1, 8'sd100, -8'sd100, -1, 1'b1, "busy");
        run_frame(1, 1, 8'sd2, 8'sd2, -1, 1'b0, "lat1");
`ifdef POINT_STEPPER_TIMEOUT_EN
        run_frame(3, 1, 8'sd0, 8'sd1, 1, 1'b0, "tmo");
        chk("timeout_set", {63'd0, to_a}, 64'd1);
`else
        chk("timeout_tied", {63'd0, to_a}, 64'd0);
`endif

        // Reset mid-frame aborts and clears everything
        m_lat = 5; m_hold = 1; m_skip = -1; m_n = 0;
        exp_beg_q.push_back('{cyc + 1, sh_px[0], sh_py[0], sh_vx[0], sh_vy[0], 8'sd4, 8'sd4});
        fs_a = 1; ax_a = 4; ay_a = 4;
        tick();
        fs_a = 0;
        tick();
        tick();
        chk("midrst_busy_before", {63'd0, busy_a}, 64'd1);
        rst = 1;
        tick();
        rst = 0;
        chk("midrst_ctrl", {busy_a, done_a, to_a, bus_a.begin_out}, 4'd0);
        chk("midrst_accel", {bus_a.accel_x_out, bus_a.accel_y_out}, 16'd0);
        chk("midrst_begins_left", 64'(exp_beg_q.size()), 64'd0);
        exp_beg_q.delete();
        for (int i = 0; i < N; i++) begin
            sh_px[i] = 0; sh_py[i] = 0; sh_vx[i] = 0; sh_vy[i] = 0;
        end
        rd_all("midrst");
        for (int b = 0; b < 8; b++) tick();
        chk("midrst_stays_idle", {63'd0, busy_a}, 64'd0);

        // Single point: out-of-range init is dropped, then one frame at L=3
        we_b = 1; widx_b = 1'b1; wpx_b = 7; wpy_b = 7; wvx_b = 7; wvy_b = 7;
        tick();
        we_b = 0; ridx_b = 1'b1;
        tick();
        chk("one_rd_oor", {rpx_b, rpy_b, rvx_b, rvy_b}, 32'd0);
        ridx_b = 1'b0;
        tick();
        chk("one_oor_not_stored", {rpx_b, rpy_b, rvx_b, rvy_b}, 32'd0);
        we_b = 1; widx_b = 1'b0; wpx_b = -4; wpy_b = -7; wvx_b = 6; wvy_b = 1;
        tick();
        we_b = 0;
        tick();
        chk("one_init_rd", {rpx_b, rpy_b, rvx_b, rvy_b}, {-8'sd4, -8'sd7, 8'sd6, 8'sd1});
        fs_b = 1; ax_b = 0; ay_b = -1;
        tick();
        fs_b = 0; ax_b = 5; ay_b = 5;
        chk("one_begin_k1", {62'd0, bus_b.begin_out, busy_b}, 64'd3);
        chk("one_ops", {bus_b.pos_x_out, bus_b.pos_y_out, bus_b.vel_x_out, bus_b.vel_y_out,
                        bus_b.accel_x_out, bus_b.accel_y_out},
            {-8'sd4, -8'sd7, 8'sd6, 8'sd1, 8'sd0, -8'sd1});
        tick();
        chk("one_begin_once", {62'd0, bus_b.begin_out, done_b}, 64'd0);
        tick();
        tick();
        bus_b.result_in = 1; bus_b.new_pos_x_in = 2; bus_b.new_pos_y_in = -7;
        bus_b.new_vel_x_in = 6; bus_b.new_vel_y_in = 0;
        tick();
        bus_b.result_in = 0;
        chk("one_done_k5", {62'd0, done_b, bus_b.begin_out}, 64'd2);
        tick();
        chk("one_idle", {62'd0, done_b, busy_b}, 64'd0);
        tick();
        chk("one_rd_final", {rpx_b, rpy_b, rvx_b, rvy_b}, {8'sd2, -8'sd7, 8'sd6, 8'sd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end
endmodule
